// File: rtl/timer_int_ctrl.sv
// Timer interrupt controller feeding the IF stage: a reloading down-counter latches
// expiries as pending, and a small FSM turns them into enter/return pulses for IF.
module timer_int_ctrl #(
    parameter int                CNT_W      = 32,
    parameter logic [CNT_W-1:0]  RST_PERIOD = CNT_W'(100)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             timer_en,
    input  logic             period_we,
    input  logic [CNT_W-1:0] period_wdata,
    input  logic             eret,
    input  logic             pc_write,
    output logic             INT_detected,
    output logic             INT_restore,
    output logic             in_isr,
    output logic             int_pending,
    output logic             int_overrun,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        ISR   = 2'd2,
        EXIT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              int_detected_q, int_detected_d;
    logic              int_restore_q, int_restore_d;
    logic              in_isr_q, in_isr_d;
    logic              expire;
    logic              take;

    always_comb begin
        expire    = (count_q == CNT_W'(1));
        take      = (state_q == IDLE) && pending_q && timer_en && pc_write;
        period_d  = period_q;
        count_d   = count_q;
        pending_d = pending_q && !take;
        overrun_d = overrun_q;

        // A period write wins over a same-cycle expiry; that expiry simply vanishes.
        if (period_we) begin
            period_d = period_wdata;
            count_d  = period_wdata;
        end else if (expire) begin
            count_d   = period_q;
            pending_d = 1'b1;
            if (pending_q && !take)
                overrun_d = 1'b1;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = ENTER;
            ENTER:   state_d = ISR;
            ISR:     if (eret) state_d = EXIT;
            EXIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        int_detected_d = (state_d == ENTER);
        int_restore_d  = (state_d == EXIT);
        in_isr_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            period_q       <= RST_PERIOD;
            count_q        <= RST_PERIOD;
            pending_q      <= 1'b0;
            overrun_q      <= 1'b0;
            int_detected_q <= 1'b0;
            int_restore_q  <= 1'b0;
            in_isr_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            period_q       <= period_d;
            count_q        <= count_d;
            pending_q      <= pending_d;
            overrun_q      <= overrun_d;
            int_detected_q <= int_detected_d;
            int_restore_q  <= int_restore_d;
            in_isr_q       <= in_isr_d;
        end
    end

    assign INT_detected = int_detected_q;
    assign INT_restore  = int_restore_q;
    assign in_isr       = in_isr_q;
    assign int_pending  = pending_q;
    assign int_overrun  = overrun_q;
    assign count        = count_q;

endmodule

// File: tb/tb_timer_int_ctrl.sv
// Directed bench for timer_int_ctrl: walks reset, entry, return, period writes,
// overrun, stall deferral and reset-during-ISR against hand-computed values.
module tb_timer_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        timer_en;
    logic        period_we;
    logic [31:0] period_wdata;
    logic        eret;
    logic        pc_write;
    logic        INT_detected;
    logic        INT_restore;
    logic        in_isr;
    logic        int_pending;
    logic        int_overrun;
    logic [31:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    int restore_pulses = 0;
    int overlap_cycles = 0;

    timer_int_ctrl #(.CNT_W(32), .RST_PERIOD(32'd100)) dut (
        .clk          (clk),
        .reset        (reset),
        .timer_en     (timer_en),
        .period_we    (period_we),
        .period_wdata (period_wdata),
        .eret         (eret),
        .pc_write     (pc_write),
        .INT_detected (INT_detected),
        .INT_restore  (INT_restore),
        .in_isr       (in_isr),
        .int_pending  (int_pending),
        .int_overrun  (int_overrun),
        .count        (count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (INT_detected && INT_restore) overlap_cycles++;
        if (INT_restore) restore_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; timer_en = 1'b1; pc_write = 1'b1;
        period_we = 1'b0; period_wdata = '0; eret = 1'b0;
        step(2);
        chk("rst_count",    count, 32'd100);
        chk("rst_det",      32'(INT_detected), 32'd0);
        chk("rst_isr",      32'(in_isr), 32'd0);
        chk("rst_pend",     32'(int_pending), 32'd0);
        chk("rst_ovr",      32'(int_overrun), 32'd0);

        // 1: first expiry after 100 cycles, entry one cycle later
        reset = 1'b1;
        step(1);  chk("t1_count99", count, 32'd99);
        step(98); chk("t1_count1",  count, 32'd1);
                  chk("t1_nopend",  32'(int_pending), 32'd0);
        step(1);  chk("t1_reload",  count, 32'd100);
                  chk("t1_pend",    32'(int_pending), 32'd1);
                  chk("t1_nodet",   32'(INT_detected), 32'd0);
        step(1);  chk("t1_det",     32'(INT_detected), 32'd1);
                  chk("t1_isr",     32'(in_isr), 32'd1);
                  chk("t1_pendclr", 32'(int_pending), 32'd0);

        // 2: eret -> INT_restore next cycle, in_isr drops after
        step(1);  chk("t2_detoff",  32'(INT_detected), 32'd0);
        eret = 1'b1;
        step(1);  chk("t2_restore", 32'(INT_restore), 32'd1);
                  chk("t2_isr_inc", 32'(in_isr), 32'd1);
        eret = 1'b0;
        step(1);  chk("t2_resoff",  32'(INT_restore), 32'd0);
                  chk("t2_isroff",  32'(in_isr), 32'd0);
                  chk("t2_count",   count, 32'd96);

        // 3: period write at count==1 beats the expiry
        step(95); chk("t3_count1",  count, 32'd1);
        period_we = 1'b1; period_wdata = 32'd5;
        step(1);  chk("t3_count5",  count, 32'd5);
                  chk("t3_nopend",  32'(int_pending), 32'd0);
        period_we = 1'b0;
        step(4);  chk("t3_nopend4", 32'(int_pending), 32'd0);
        step(1);  chk("t3_pend",    32'(int_pending), 32'd1);
                  chk("t3_ovr",     32'(int_overrun), 32'd0);
        step(1);  chk("t3_det",     32'(INT_detected), 32'd1);

        // 4: two expiries while in ISR -> overrun, re-entry 2 cycles after restore
        period_we = 1'b1; period_wdata = 32'd4;
        step(1);  chk("t4_count4",  count, 32'd4);
        period_we = 1'b0;
        step(4);  chk("t4_pend",    32'(int_pending), 32'd1);
                  chk("t4_noovr",   32'(int_overrun), 32'd0);
        step(4);  chk("t4_ovr",     32'(int_overrun), 32'd1);
                  chk("t4_stay",    32'(in_isr), 32'd1);
        eret = 1'b1;
        step(1);  chk("t4_restore", 32'(INT_restore), 32'd1);
        eret = 1'b0;
        step(1);  chk("t4_idle_det", 32'(INT_detected), 32'd0);
                  chk("t4_idle_pend", 32'(int_pending), 32'd1);
        step(1);  chk("t4_redet",   32'(INT_detected), 32'd1);
                  chk("t4_count1",  count, 32'd1);

        // 5: stall defers entry, pulse one cycle after pc_write rises
        step(1);  chk("t5_pend",    32'(int_pending), 32'd1);
        eret = 1'b1;
        step(1);  chk("t5_restore", 32'(INT_restore), 32'd1);
        eret = 1'b0; pc_write = 1'b0;
        step(1);  chk("t5_stall1",  32'(INT_detected), 32'd0);
        step(1);  chk("t5_stall2",  32'(INT_detected), 32'd0);
        step(1);  chk("t5_stall3",  32'(INT_detected), 32'd0);
                  chk("t5_held",    32'(int_pending), 32'd1);
        pc_write = 1'b1;
        step(1);  chk("t5_det",     32'(INT_detected), 32'd1);
                  chk("t5_pendclr", 32'(int_pending), 32'd0);

        // 6: reset during ISR, then stop the timer with period 0
        step(1);  chk("t6_inisr",   32'(in_isr), 32'd1);
        reset = 1'b0;
        step(1);  chk("t6_isr0",    32'(in_isr), 32'd0);
                  chk("t6_res0",    32'(INT_restore), 32'd0);
                  chk("t6_ovr0",    32'(int_overrun), 32'd0);
                  chk("t6_count",   count, 32'd100);
        reset = 1'b1; period_we = 1'b1; period_wdata = 32'd0;
        step(1);  chk("t6_zero",    count, 32'd0);
        period_we = 1'b0;
        step(20); chk("t6_hold0",   count, 32'd0);
                  chk("t6_nopend",  32'(int_pending), 32'd0);
                  chk("t6_nodet",   32'(INT_detected), 32'd0);
                  chk("t6_noisr",   32'(in_isr), 32'd0);

        chk("restore_pulses", 32'(restore_pulses), 32'd3);
        chk("no_overlap",     32'(overlap_cycles), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
